// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU control decoder and the EX-stage execution
// unit: 6-bit ALU control codes and the execution-unit FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [5:0] ALU_ADD     = 6'b100000;
  localparam logic [5:0] ALU_SUB     = 6'b100010;
  localparam logic [5:0] ALU_AND     = 6'b100100;
  localparam logic [5:0] ALU_OR      = 6'b100101;
  localparam logic [5:0] ALU_NOR     = 6'b100111;
  localparam logic [5:0] ALU_XOR     = 6'b100110;
  localparam logic [5:0] ALU_MUL     = 6'b011000;
  localparam logic [5:0] ALU_SLL     = 6'b000000;
  localparam logic [5:0] ALU_SRL     = 6'b111111;
  localparam logic [5:0] ALU_SLT     = 6'b101010;
  localparam logic [5:0] ALU_JR      = 6'b001000;
  localparam logic [5:0] ALU_BEQ     = 6'b000100;
  localparam logic [5:0] ALU_BNE     = 6'b000101;
  localparam logic [5:0] ALU_BGTZ    = 6'b000111;
  localparam logic [5:0] ALU_BLEZ    = 6'b000110;
  localparam logic [5:0] ALU_REGIMM  = 6'b000001;  // BLTZ / BGEZ selected by rt[0]
  localparam logic [5:0] ALU_J       = 6'b000010;
  localparam logic [5:0] ALU_JAL     = 6'b000011;
  localparam logic [5:0] ALU_DEFAULT = 6'b010101;  // decoder's "no valid op" code

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul
// Iterative shift-add multiplier, one multiplier bit per cycle, WIDTH cycles.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - load a/b and begin (ignored semantics: always restarts)
//   a, b      - multiplicand, multiplier
//   busy      - iterations in progress
//   done      - one-cycle pulse; product is valid while done is high
//   product   - low WIDTH bits of a*b
module alu_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  import alu_ctrl_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      // The iteration at count zero is the last one; done flags it next cycle.
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// EX-stage execution unit: valid/ready handshake around a single-cycle ALU
// datapath plus an iterative multiplier.
// Ports:
//   Clk, Reset          - clock, asynchronous active-high reset
//   InValid / InReady   - input handshake (ALUCtl, A, B, Shamt, RtSel)
//   OutValid / OutReady - output handshake (Result, Zero, BranchTaken, Illegal)
//   Result              - registered ALU result; A-B for branch codes
//   Zero                - Result == 0, registered alongside Result
//   BranchTaken         - branch condition for branch codes, else 0
//   Illegal             - code was not a listed operation
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [5:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  input  logic             RtSel,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             BranchTaken,
  output logic             Illegal
);
  import alu_ctrl_pkg::*;

  exec_state_e      state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             branch_q, branch_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             is_mul;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] alu_res;
  logic             alu_br;
  logic             alu_ill;
  logic [WIDTH-1:0] diff;
  logic             a_neg, a_zero;

  assign accept = InValid & InReady;
  assign is_mul = (ALUCtl == ALU_MUL);

  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .rst     (Reset),
    .start   (accept & is_mul),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath, evaluated straight from the presented operands.
  assign diff   = A - B;
  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (ALUCtl)
      ALU_ADD:    alu_res = A + B;
      ALU_SUB:    alu_res = diff;
      ALU_AND:    alu_res = A & B;
      ALU_OR:     alu_res = A | B;
      ALU_NOR:    alu_res = ~(A | B);
      ALU_XOR:    alu_res = A ^ B;
      ALU_MUL:    alu_res = '0;
      ALU_SLL:    alu_res = B << Shamt;
      ALU_SRL:    alu_res = B >> Shamt;
      ALU_SLT:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_JR:     alu_res = A;
      ALU_BEQ:    begin alu_res = diff; alu_br = (A == B);           end
      ALU_BNE:    begin alu_res = diff; alu_br = (A != B);           end
      ALU_BGTZ:   begin alu_res = diff; alu_br = !a_neg && !a_zero;  end
      ALU_BLEZ:   begin alu_res = diff; alu_br = a_neg || a_zero;    end
      ALU_REGIMM: begin alu_res = diff; alu_br = RtSel ? !a_neg : a_neg; end
      ALU_J, ALU_JAL: alu_res = '0;
      default:    alu_ill = 1'b1;
    endcase
  end

  // Handshake FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshake FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = is_mul ? ST_MUL_BUSY : ST_DONE;
      end
      ST_MUL_BUSY: begin
        if (mul_done && !mul_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (OutReady) begin
          if (InValid) state_d = is_mul ? ST_MUL_BUSY : ST_DONE;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake FSM: outputs
  always_comb begin
    InReady  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OutReady);
    OutValid = (state_q == ST_DONE);
  end

  // Result registers only change when a result is produced, so they stay
  // stable through backpressure and through the multiply iterations.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    if (accept && !is_mul) begin
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      branch_d  = alu_br;
      illegal_d = alu_ill;
    end else if ((state_q == ST_MUL_BUSY) && mul_done) begin
      result_d  = mul_product;
      zero_d    = (mul_product == '0);
      branch_d  = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
    end
  end

  assign Result      = result_q;
  assign Zero        = zero_q;
  assign BranchTaken = branch_q;
  assign Illegal     = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  import alu_ctrl_pkg::*;

  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             InValid;
  logic             InReady;
  logic [5:0]       ALUCtl;
  logic [WIDTH-1:0] A, B;
  logic [4:0]       Shamt;
  logic             RtSel;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero, BranchTaken, Illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .ALUCtl      (ALUCtl),
    .A           (A),
    .B           (B),
    .Shamt       (Shamt),
    .RtSel       (RtSel),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Result      (Result),
    .Zero        (Zero),
    .BranchTaken (BranchTaken),
    .Illegal     (Illegal)
  );

  always #5 Clk = ~Clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one operation for a single edge, then drop InValid.
  task automatic issue_op(input logic [5:0] code, input logic [WIDTH-1:0] a_v,
                          input logic [WIDTH-1:0] b_v, input logic [4:0] sh,
                          input logic rt);
    ALUCtl  = code;
    A       = a_v;
    B       = b_v;
    Shamt   = sh;
    RtSel   = rt;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    ALUCtl = ALU_ADD; A = '0; B = '0; Shamt = '0; RtSel = 1'b0;
    tick(); tick();
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
    n_checks++; if (Result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", Result); end
    n_checks++; if ({Zero, BranchTaken, Illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {Zero, BranchTaken, Illegal}); end
    Reset = 1'b0;
    tick();
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b expected 1", InReady); end
  endtask

  task automatic test_add_sub();
    issue_op(ALU_ADD, 32'd7, 32'd5, 5'd0, 1'b0);
    n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", OutValid); end
    n_checks++; if (Result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h expected 0000000c", Result); end
    n_checks++; if (Zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b expected 0", Zero); end
    tick();
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL add_idle: got %b expected 0", OutValid); end
    issue_op(ALU_SUB, 32'd5, 32'd5, 5'd0, 1'b0);
    n_checks++; if (Result !== 32'd0) begin n_fail++; $display("FAIL sub_result: got %h expected 0", Result); end
    n_checks++; if (Zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b expected 1", Zero); end
    tick();
  endtask

  task automatic test_mul();
    int n;
    int ready_seen;
    n = 0; ready_seen = 0;
    issue_op(ALU_MUL, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b0);
    while (!OutValid && n < 100) begin
      if (InReady) ready_seen++;
      tick();
      n++;
    end
    n_checks++; if (n !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d edges expected 33", n); end
    n_checks++; if (ready_seen !== 0) begin n_fail++; $display("FAIL mul_inready: got %0d ready cycles expected 0", ready_seen); end
    n_checks++; if (Result !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mul_result: got %h expected fffffffd", Result); end
    n_checks++; if ({BranchTaken, Illegal} !== 2'b00) begin n_fail++; $display("FAIL mul_flags: got %b expected 00", {BranchTaken, Illegal}); end
    tick();
    // Multiply 6*7 to check a second product value.
    n = 0;
    issue_op(ALU_MUL, 32'd6, 32'd7, 5'd0, 1'b0);
    while (!OutValid && n < 100) begin tick(); n++; end
    n_checks++; if (Result !== 32'd42) begin n_fail++; $display("FAIL mul_small: got %h expected 0000002a", Result); end
    tick();
  endtask

  task automatic test_mul_reset_abort();
    int valid_seen;
    valid_seen = 0;
    issue_op(ALU_MUL, 32'hFFFF_FFFF, 32'd3, 5'd0, 1'b0);
    repeat (9) tick();
    Reset = 1'b1;
    #1;
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL abort_outvalid: got %b expected 0", OutValid); end
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got InReady %b expected 1", InReady); end
    tick();
    Reset = 1'b0;
    repeat (40) begin
      tick();
      if (OutValid) valid_seen++;
    end
    n_checks++; if (valid_seen !== 0) begin n_fail++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", valid_seen); end
    n_checks++; if (Result !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h expected 0", Result); end
  endtask

  task automatic test_branches();
    issue_op(ALU_BEQ, 32'd9, 32'd9, 5'd0, 1'b0);
    n_checks++; if (BranchTaken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b expected 1", BranchTaken); end
    n_checks++; if ({Result, Zero} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL beq_result: got %h/%b expected 0/1", Result, Zero); end
    tick();
    issue_op(ALU_BNE, 32'd10, 32'd3, 5'd0, 1'b0);
    n_checks++; if ({BranchTaken, Result} !== {1'b1, 32'd7}) begin n_fail++; $display("FAIL bne: got %b/%h expected 1/00000007", BranchTaken, Result); end
    tick();
    issue_op(ALU_REGIMM, 32'h8000_0000, 32'd0, 5'd0, 1'b0);
    n_checks++; if (BranchTaken !== 1'b1) begin n_fail++; $display("FAIL bltz_neg: got %b expected 1", BranchTaken); end
    tick();
    issue_op(ALU_REGIMM, 32'h8000_0000, 32'd0, 5'd0, 1'b1);
    n_checks++; if (BranchTaken !== 1'b0) begin n_fail++; $display("FAIL bgez_neg: got %b expected 0", BranchTaken); end
    tick();
    issue_op(ALU_BLEZ, 32'd0, 32'd0, 5'd0, 1'b0);
    n_checks++; if (BranchTaken !== 1'b1) begin n_fail++; $display("FAIL blez_zero: got %b expected 1", BranchTaken); end
    tick();
    issue_op(ALU_BGTZ, 32'd0, 32'd0, 5'd0, 1'b0);
    n_checks++; if (BranchTaken !== 1'b0) begin n_fail++; $display("FAIL bgtz_zero: got %b expected 0", BranchTaken); end
    tick();
    issue_op(ALU_BGTZ, 32'd1, 32'd0, 5'd0, 1'b0);
    n_checks++; if (BranchTaken !== 1'b1) begin n_fail++; $display("FAIL bgtz_pos: got %b expected 1", BranchTaken); end
    tick();
    issue_op(ALU_ADD, 32'd1, 32'd0, 5'd0, 1'b0);
    n_checks++; if (BranchTaken !== 1'b0) begin n_fail++; $display("FAIL nonbranch_taken: got %b expected 0", BranchTaken); end
    tick();
  endtask

  task automatic test_shifts_misc();
    issue_op(ALU_SLL, 32'd0, 32'd1, 5'd31, 1'b0);
    n_checks++; if (Result !== 32'h8000_0000) begin n_fail++; $display("FAIL sll31: got %h expected 80000000", Result); end
    tick();
    issue_op(ALU_SRL, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
    n_checks++; if (Result !== 32'h1) begin n_fail++; $display("FAIL srl31: got %h expected 00000001", Result); end
    tick();
    issue_op(ALU_SLT, 32'hFFFF_FFFF, 32'd0, 5'd0, 1'b0);
    n_checks++; if (Result !== 32'h1) begin n_fail++; $display("FAIL slt_signed: got %h expected 00000001", Result); end
    tick();
    issue_op(ALU_NOR, 32'h0000_00F0, 32'h0000_000F, 5'd0, 1'b0);
    n_checks++; if (Result !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL nor: got %h expected ffffff00", Result); end
    tick();
    issue_op(ALU_JR, 32'h0000_1234, 32'd5, 5'd0, 1'b0);
    n_checks++; if (Result !== 32'h0000_1234) begin n_fail++; $display("FAIL jr: got %h expected 00001234", Result); end
    tick();
    issue_op(ALU_JAL, 32'h0000_1234, 32'd5, 5'd0, 1'b0);
    n_checks++; if ({Result, BranchTaken, Illegal} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL jal: got %h/%b/%b expected 0/0/0", Result, BranchTaken, Illegal); end
    tick();
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    OutReady = 1'b0;
    issue_op(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 1'b0);
    repeat (5) begin
      if (!OutValid || Result !== 32'h0000_0FF0 || InReady) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL xor_hold: got %0d bad cycles expected 0 (Result %h)", bad, Result); end
    ALUCtl = ALU_OR; A = 32'd1; B = 32'd2; InValid = 1'b1; OutReady = 1'b1;
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_inready: got %b expected 1", InReady); end
    tick();
    InValid = 1'b0;
    n_checks++; if ({OutValid, Result} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL b2b_or: got %b/%h expected 1/00000003", OutValid, Result); end
    tick();
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", OutValid); end
  endtask

  task automatic test_illegal();
    issue_op(ALU_ADD, 32'd3, 32'd4, 5'd0, 1'b0);
    tick();
    issue_op(ALU_DEFAULT, 32'd3, 32'd4, 5'd0, 1'b0);
    n_checks++; if ({OutValid, Illegal, Result} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL illegal_010101: got %b/%b/%h expected 1/1/0", OutValid, Illegal, Result); end
    tick();
    issue_op(6'b110011, 32'd3, 32'd4, 5'd0, 1'b0);
    n_checks++; if ({OutValid, Illegal, Result} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL illegal_110011: got %b/%b/%h expected 1/1/0", OutValid, Illegal, Result); end
    tick();
    issue_op(ALU_AND, 32'hF0, 32'h3C, 5'd0, 1'b0);
    n_checks++; if ({Illegal, Result} !== {1'b0, 32'h30}) begin n_fail++; $display("FAIL legal_after_illegal: got %b/%h expected 0/00000030", Illegal, Result); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_mul_reset_abort();
    test_branches();
    test_shifts_misc();
    test_back_to_back();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 6-bit ALU control code produced by the ALU control decoder.
- Accepts operands plus control code through a valid/ready handshake and computes the result and branch decision.
- MUL runs as an iterative shift-add over several cycles; every other operation completes in one cycle.
- Sits in the EX stage, between the ID/EX register and the EX/MEM register. The hazard logic stalls on InReady/OutValid.

Parameters:
- WIDTH, 32, operand/result width in bits; the MUL iteration count equals WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  operands and code are presented
- InReady  output  1  unit can accept this cycle
- ALUCtl  input  6  control code from the ALU control decoder
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand or sign-extended immediate
- Shamt  input  5  shift amount for SLL/SRL
- RtSel  input  1  rt[0] for opcode 000001: 0 = BLTZ, 1 = BGEZ
- OutValid  output  1  Result/BranchTaken valid
- OutReady  input  1  downstream accepts the result
- Result  output  WIDTH  computed value
- Zero  output  1  Result == 0
- BranchTaken  output  1  branch condition true
- Illegal  output  1  code was 010101 or unlisted

Behaviour:
- Reset (async, active-high) forces state=IDLE and clears OutValid, Result, Zero, BranchTaken, Illegal and the iteration counter. InReady=1 once Reset deasserts.
- States:
  - IDLE: InReady=1.
  - MUL_BUSY: InReady=0, OutValid=0.
  - DONE: OutValid=1.
  - InReady = (IDLE) or (DONE and OutReady).
- An operation is accepted when InValid & InReady. The operands, code, Shamt and RtSel are captured on that edge.
- Single-cycle ops go to DONE with the result registered on the accept edge: OutValid rises 1 cycle after accept.
- MUL (011000) goes to MUL_BUSY.
  - Counter loads WIDTH-1.
  - Each cycle: if multiplier lsb=1, add multiplicand; shift multiplicand left and multiplier right.
  - Enter DONE when counter==0. OutValid rises exactly WIDTH+1 cycles after accept (33 for WIDTH=32).
- DONE exit:
  - Holds all outputs stable until OutReady.
  - OutReady & InValid: back-to-back accept; the next op is processed with no bubble.
  - OutReady & !InValid: go to IDLE, OutValid=0.
- Codes:
  - 100000 ADD: A+B
  - 100010 SUB: A-B
  - 100100 AND
  - 100101 OR
  - 100111 NOR
  - 100110 XOR
  - 011000 MUL: low WIDTH bits of A*B
  - 000000 SLL: B<<Shamt
  - 111111 SRL: B>>Shamt, logical
  - 101010 SLT: signed A<B ? 1 : 0
  - 001000 JR: Result=A
  - 000100 BEQ: A==B
  - 000101 BNE: A!=B
  - 000111 BGTZ: A>0 signed
  - 000110 BLEZ: A<=0 signed
  - 000001: A<0 if RtSel=0, A>=0 if RtSel=1
  - 000010 J, 000011 JAL: Result=0, BranchTaken=0
  - any other code, including 010101: Result=0, Illegal=1, completes in 1 cycle
- Arithmetic wraps modulo 2^WIDTH; there is no overflow trap.
- For branch codes, Result = A-B and BranchTaken is computed as listed above. For non-branch codes BranchTaken=0.
- Zero is always derived from the registered Result.
- Reset during MUL_BUSY aborts the operation; no partial result is ever presented.
- InValid while in MUL_BUSY is ignored; the upstream holds its data.

Decomposition:
- Shared package alu_ctrl_pkg holds the 6-bit code localparams (ALU_ADD … ALU_JAL, ALU_SRL=6'b111111, ALU_DEFAULT=6'b010101) and the FSM state encoding. The same package is used by the ALU control decoder.
- One sub-module, alu_iter_mul: start/busy/done, WIDTH-parameterised shift-add core with its own counter.
- alu_exec_unit keeps the handshake FSM and the combinational single-cycle datapath.

Test Plan:
- Reset, then ADD A=7 B=5 with OutReady=1 → OutValid 1 cycle later, Result=12, Zero=0; then SUB A=5 B=5 → Result=0, Zero=1.
- MUL A=0xFFFFFFFF B=3 → InReady=0 for 32 cycles; OutValid at cycle 33, Result=0xFFFFFFFD. Assert Reset at cycle 10 → OutValid=0, state IDLE, no result appears.
- Branches:
  - BEQ A=B=9 → BranchTaken=1.
  - 000001 A=0x80000000: RtSel=0 → 1; RtSel=1 → 0.
  - BLEZ A=0 → 1.
  - BGTZ A=0 → 0.
- SLL B=1 Shamt=31 → 0x80000000. SRL B=0x80000000 Shamt=31 → 1. SLT A=-1 B=0 → 1.
- Backpressure: hold OutReady=0 for 5 cycles after XOR → Result stable, InReady=0. Raise OutReady with InValid=1 (OR) → OR accepted the same edge, next OutValid 1 cycle later.
- Code 010101 and code 110011 → Illegal=1, Result=0, 1-cycle completion.
